// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned MAX_WORDS = 64;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-lane assembler: packs accepted bytes little-endian into 32-bit words
// and raises word_valid for one cycle after the fourth byte of each word.
//   clk, reset   : clock, async active-high reset
//   clr          : session restart, drops any partial word
//   acc, data    : accepted data byte strobe and value
//   lane_last_c  : the next accepted byte completes a word
//   word_valid   : one-cycle write strobe
//   word         : assembled word, held between strobes
module loader_word_asm
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              acc,
   input  logic [BYTE_W-1:0] data,
   output logic              lane_last_c,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [1:0]               byte_idx;
   logic [WORD_W-BYTE_W-1:0] lanes;

   assign lane_last_c = (byte_idx == 2'd3);

   // Lane capture; the top lane goes straight into the output word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx   <= 2'd0;
         lanes      <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clr) begin
            byte_idx <= 2'd0;
            lanes    <= '0;
         end else if (acc) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    lanes[7:0]   <= data;
               2'd1:    lanes[15:8]  <= data;
               2'd2:    lanes[23:16] <= data;
               default: begin
                  word       <= {data, lanes};
                  word_valid <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (word count, data, XOR checksum),
// writes little-endian words to instruction memory from address 0 and holds
// the CPU in reset until a load completes cleanly.
//   clk, reset          : clock, async active-high reset
//   start               : begin a session when not busy
//   in_valid/in_data    : byte stream, accepted when in_ready is high
//   in_ready            : decoded from state only
//   mem_we/adr/wd       : instruction memory write port
//   cpu_reset           : CPU reset hold
//   busy/done/error     : session status
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [WORD_W-1:0] mem_wd,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_t              state, state_n;
   logic [BYTE_W-1:0]   n_words, n_words_n;
   logic [BYTE_W-1:0]   chk, chk_n;
   logic [IDX_W-1:0]    word_idx, word_idx_n;
   logic [TMO_W-1:0]    tmo, tmo_n;
   logic [ADDR_W-1:0]   adr_n;
   logic                clr;
   logic                accept;
   logic                data_acc;
   logic                lane_last_c;

   assign in_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
   assign accept   = in_valid & in_ready;
   assign data_acc = accept & (state == S_DATA);

   loader_word_asm u_asm (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .acc         (data_acc),
      .data        (in_data),
      .lane_last_c (lane_last_c),
      .word_valid  (mem_we),
      .word        (mem_wd)
   );

   // Next-state, counters and checksum.
   always_comb begin
      state_n    = state;
      n_words_n  = n_words;
      chk_n      = chk;
      word_idx_n = word_idx;
      tmo_n      = tmo;
      adr_n      = mem_adr;
      clr        = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_n    = S_COUNT;
               clr        = 1'b1;
               n_words_n  = '0;
               chk_n      = '0;
               word_idx_n = '0;
               tmo_n      = '0;
            end
         end
         S_COUNT: begin
            if (accept) begin
               chk_n = in_data;
               if ((in_data == '0) || (in_data > BYTE_W'(MAX_WORDS))) begin
                  state_n = S_ERROR;
               end else begin
                  n_words_n = in_data;
                  state_n   = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               chk_n = chk ^ in_data;
               if (lane_last_c) begin
                  // Address is latched here so it lines up with the strobe.
                  adr_n      = {word_idx, 2'b00};
                  word_idx_n = word_idx + IDX_W'(1);
                  if (BYTE_W'(word_idx) == n_words - BYTE_W'(1)) begin
                     state_n = S_CHECK;
                  end
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_n = (in_data == chk) ? S_DONE : S_ERROR;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Inactivity watchdog; an accept on the firing edge wins.
      if (in_ready) begin
         if (accept) begin
            tmo_n = '0;
         end else begin
            tmo_n = tmo + TMO_W'(1);
            if (tmo == TMO_W'(TIMEOUT - 1)) begin
               state_n = S_ERROR;
            end
         end
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         n_words   <= '0;
         chk       <= '0;
         word_idx  <= '0;
         tmo       <= '0;
         mem_adr   <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         n_words   <= n_words_n;
         chk       <= chk_n;
         word_idx  <= word_idx_n;
         tmo       <= tmo_n;
         mem_adr   <= adr_n;
         cpu_reset <= (state_n != S_DONE);
         busy      <= (state_n == S_COUNT) || (state_n == S_DATA) || (state_n == S_CHECK);
         done      <= (state_n == S_DONE);
         error     <= (state_n == S_ERROR);
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of short sessions plus
// hand-written multi-cycle sequences; writes checked through a scoreboard.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_adr;
   logic [31:0] mem_wd;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;
   int n_wr  = 0;

   typedef struct packed {
      logic [7:0]  adr;
      logic [31:0] wd;
   } wr_t;
   wr_t exp_q[$];

   typedef struct packed {
      logic [7:0]  cnt;
      logic [31:0] w;
      logic [7:0]  ck;
      logic        exp_done;
      logic        exp_err;
   } vec_t;
   localparam int NV = 7;
   vec_t vecs [NV];

   prog_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wd    (mem_wd),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got adr=%h wd=%h want none", mem_adr, mem_wd);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_adr", 32'(mem_adr), 32'(e.adr));
            check("wr_wd", mem_wd, e.wd);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] adr, input logic [31:0] w, input int gap);
      wr_t e;
      e.adr = adr;
      e.wd  = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] t;
         t = w >> (8 * k);
         send_byte(t[7:0]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
      check({tag, "_mem_wd"}, mem_wd, 32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
   endtask

   task automatic check_end(input string tag, input logic d, input logic e);
      check({tag, "_done"}, 32'(done), 32'(d));
      check({tag, "_error"}, 32'(error), 32'(e));
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!d));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0]  ck;
      logic [31:0] w;
      int          wr0;

      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      vecs[0] = '{cnt: 8'h01, w: 32'h12345678, ck: 8'h09, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{cnt: 8'h01, w: 32'h12345678, ck: 8'h0A, exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{cnt: 8'h01, w: 32'hDEADBEEF, ck: 8'h23, exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{cnt: 8'h01, w: 32'hFFFFFFFF, ck: 8'h01, exp_done: 1'b1, exp_err: 1'b0};
      vecs[4] = '{cnt: 8'h01, w: 32'h00000000, ck: 8'h00, exp_done: 1'b0, exp_err: 1'b1};
      vecs[5] = '{cnt: 8'h00, w: 32'h0,        ck: 8'h00, exp_done: 1'b0, exp_err: 1'b1};
      vecs[6] = '{cnt: 8'h41, w: 32'h0,        ck: 8'h00, exp_done: 1'b0, exp_err: 1'b1};

      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("idle");

      // Table of short sessions.
      for (int i = 0; i < NV; i++) begin
         wr0 = n_wr;
         pulse_start();
         check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
         send_byte(vecs[i].cnt);
         if (vecs[i].cnt == 8'h01) begin
            send_word(8'h00, vecs[i].w, 0);
            send_byte(vecs[i].ck);
         end
         check_end($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err);
         check($sformatf("v%0d_nwr", i), 32'(n_wr - wr0), (vecs[i].cnt == 8'h01) ? 32'd1 : 32'd0);
      end

      // Full capacity with idle gaps below the timeout.
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h40);
      ck = 8'h40;
      for (int k = 0; k < 64; k++) begin
         w  = $urandom;
         ck = ck ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
         send_word(8'(4 * k), w, int'($urandom_range(0, 3)));
      end
      send_byte(ck);
      idle(1);
      check_end("full", 1'b1, 1'b0);
      check("full_nwr", 32'(n_wr - wr0), 32'd64);

      // Timeout after a partial word.
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'hAA);
      idle(15);
      check("tmo15_busy", 32'(busy), 32'd1);
      check("tmo15_error", 32'(error), 32'd0);
      idle(1);
      check_end("tmo16", 1'b0, 1'b1);
      idle(2);
      check("tmo_nwr", 32'(n_wr - wr0), 32'd0);

      // Byte accepted on the edge the timeout would fire.
      pulse_start();
      send_byte(8'h01);
      idle(15);
      send_word(8'h00, 32'h12345678, 0);
      send_byte(8'h09);
      check_end("tmo_edge", 1'b1, 1'b0);

      // Reset in the middle of a data word.
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      check("midrst_nwr", 32'(n_wr - wr0), 32'd0);
      pulse_start();
      send_byte(8'h01);
      send_word(8'h00, 32'h12345678, 0);
      send_byte(8'h09);
      check_end("after_rst", 1'b1, 1'b0);

      // start during DATA is ignored; start in DONE restarts.
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h01);
      send_word(8'h00, 32'h0BADF00D, 0);
      ck = 8'h01 ^ 8'h0D ^ 8'hF0 ^ 8'hAD ^ 8'h0B;
      send_byte(ck);
      check_end("pre_dstart", 1'b1, 1'b0);
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h78);
      send_byte(8'h56);
      pulse_start();
      check("dstart_busy", 32'(busy), 32'd1);
      send_byte(8'h34);
      exp_q.push_back('{adr: 8'h00, wd: 32'h12345678});
      send_byte(8'h12);
      send_byte(8'h09);
      check_end("dstart", 1'b1, 1'b0);
      check("dstart_nwr", 32'(n_wr - wr0), 32'd1);
      pulse_start();
      check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
      check("restart_done", 32'(done), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      send_byte(8'h00);
      check_end("restart_abort", 1'b0, 1'b1);

      idle(3);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory the CPU core fetches from (8-bit byte address, 32-bit words, PC steps by 4).
- Receives a byte stream with a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially from address 0x00.
- Validates the stream with an XOR checksum and holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 8, instruction memory byte-address width; word capacity is 2**ADDR_W/4 = 64.
- TIMEOUT, 16, consecutive cycles without an accepted byte during a session before ERROR.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values
- start  input  1  one-cycle pulse; begins a load session when not busy
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe
- mem_adr  output  ADDR_W  byte address of the write, always a multiple of 4
- mem_wd  output  32  write data
- cpu_reset  output  1  holds the CPU core in reset
- busy  output  1  session in progress
- done  output  1  last session succeeded
- error  output  1  last session failed

Behaviour:
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_adr=0, mem_wd=0, cpu_reset=1, busy=0, done=0, error=0. Internal counters and checksum are 0.
- Handshake: a byte is accepted on an edge where in_valid & in_ready. in_ready is 1 exactly in COUNT, DATA and CHECK; it is combinational from state only and never from in_valid.
- States:
  - IDLE/DONE/ERROR: on start -> COUNT; clear done, error, word index, byte index, checksum and timeout; set cpu_reset=1.
  - start during COUNT/DATA/CHECK is ignored.
  - COUNT: the accepted byte is N, the word count; chk = N.
    - N==0 or N>64 -> ERROR on the same edge.
    - Otherwise store N -> DATA.
  - DATA: each accepted byte is XORed into chk and placed into byte lane byte_idx (first byte -> bits [7:0]); byte_idx wraps 3->0.
    - On the 4th byte of a word: the next cycle asserts mem_we for exactly one cycle with mem_adr = 4*word_idx and mem_wd = the assembled word; word_idx then increments.
    - After the byte that completes word N-1 -> CHECK.
  - CHECK: the accepted byte is compared to chk.
    - Equal -> DONE: done=1, cpu_reset=0 from the next cycle.
    - Not equal -> ERROR: error=1, cpu_reset stays 1.
- Timeout: in COUNT/DATA/CHECK a counter increments on each cycle with no accepted byte and clears on accept. When it reaches TIMEOUT, the next state is ERROR.
- busy = 1 in COUNT/DATA/CHECK. done and error are levels held until the next accepted start or reset.
- mem_adr/mem_wd hold their last write values when mem_we=0.
- Boundaries:
  - N=64 writes addresses 0x00..0xFC with no wrap.
  - A byte accepted on the same edge the timeout would fire counts as accepted; no timeout occurs.
  - The mem_we pulse for the final word is issued even though the state is already CHECK.
- Reset mid-session: an incomplete word is discarded and no further mem_we is issued. Memory words already written are left as-is. cpu_reset returns to 1.
- Error paths never deassert cpu_reset.

Decomposition:
- Shared package: state encoding (IDLE, COUNT, DATA, CHECK, DONE, ERROR), MAX_WORDS=64, and the 32-bit instruction word width.
- One natural sub-module: loader_word_asm, the byte-lane shifter, byte index and write-strobe register. It takes the accept strobe and byte and produces word_valid and word. The FSM, word index, checksum and timeout stay in the top.

Test Plan:
- One word: start; bytes 01,78,56,34,12,09 back-to-back -> one mem_we pulse, mem_adr=0x00, mem_wd=0x12345678; then done=1, cpu_reset=0, error=0.
- Bad checksum: same stream with final byte 0x0A -> write still occurs; error=1, done=0, cpu_reset=1.
- Full capacity: N=0x40 with 256 data bytes and gaps of in_valid=0 under TIMEOUT -> 64 pulses at 0x00..0xFC, done=1. N=0x41 or N=0x00 -> error=1 after the count byte, no mem_we.
- Timeout: start; send 01,AA; hold in_valid=0 for 16 cycles -> error=1, busy=0, no mem_we.
- Reset mid-DATA after bytes 01,11,22 -> immediately all outputs at reset values, no mem_we. A following start plus the valid one-word stream loads normally.
- start pulsed during DATA -> ignored, session completes. start pulsed in DONE -> cpu_reset=1, done=0 the next cycle.
